char_buffer_arbiter: RTL

Shared 64-entry character buffer (4 rows × 16 columns) that feeds the text engine's character fetch port and arbitrates write access among up to four text producers (UART row, binary row, hex/dec row, status row). It sits between the row formatters and the text engine. It replaces the per-row formatter mux with one buffer and one round-robin write scheduler. It also sequences a full-buffer clear to ASCII space (0x20) on reset and on request.

---
 rtl/char_buffer_arbiter_if.sv | 28 ++
 rtl/char_buffer_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/char_buffer_arbiter_if.sv
// char_buffer_arbiter_if
// Bundles the producer write port, the clear control and the text-engine read
// port of the shared character buffer.
//   req / reqAddr / reqData : four packed write requesters ({row,col}, char)
//   grant                   : one-hot write commit, combinational
//   clearReq / busy         : full-buffer clear request and sweep-in-progress
//   charAddress / charOutput: registered read port
// master = producers + text engine side, slave = the buffer.
interface char_buffer_arbiter_if;
  logic [3:0]  req;
  logic [23:0] reqAddr;
  logic [31:0] reqData;
  logic [3:0]  grant;
  logic        clearReq;
  logic        busy;
  logic [5:0]  charAddress;
  logic [7:0]  charOutput;

  modport master (
    output req, reqAddr, reqData, clearReq, charAddress,
    input  grant, busy, charOutput
  );

  modport slave (
    input  req, reqAddr, reqData, clearReq, charAddress,
    output grant, busy, charOutput
  );
endinterface

// File: rtl/char_buffer_arbiter.sv
// char_buffer_arbiter
// 64-entry (4 rows x 16 cols) character buffer shared by up to four row
// producers. Writes are scheduled round-robin, one per cycle; the buffer is
// swept to CLEAR_CHAR after reset and whenever clearReq is seen in RUN.
// Ports:
//   clk    : system clock, rising edge
//   resetN : synchronous active-low reset
//   bus    : char_buffer_arbiter_if.slave (write requests, grant, clear, read)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | sweep clr_ptr 0..63 writing CLEAR_CHAR, no grants, busy=1
// ST_RUN   | round-robin write arbitration, clearReq starts a new sweep
module char_buffer_arbiter #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input logic             clk,
  input logic             resetN,
  char_buffer_arbiter_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t     state, state_nxt;
  logic [5:0] clr_ptr, clr_ptr_nxt;
  logic [1:0] last_grant, last_grant_nxt;
  logic       busy_q;
  logic [7:0] char_q;
  logic [3:0] grant_int;

  logic [7:0] mem [64];
  logic       mem_we;
  logic [5:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic [5:0] req_addr [4];
  logic [7:0] req_data [4];

  logic       rr_valid;
  logic [1:0] rr_sel;
  logic [1:0] rr_cand;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = bus.reqAddr[6*i +: 6];
      req_data[i] = bus.reqData[8*i +: 8];
    end
  end

  // Search starts one past the last winner; the fourth candidate wraps back
  // to last_grant itself so a lone requester keeps winning every cycle.
  always_comb begin
    rr_valid = 1'b0;
    rr_sel   = last_grant;
    rr_cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_grant + 2'(k);
      if (!rr_valid && bus.req[rr_cand]) begin
        rr_valid = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    clr_ptr_nxt    = clr_ptr;
    last_grant_nxt = last_grant;
    grant_int      = '0;
    mem_we         = 1'b0;
    mem_waddr      = clr_ptr;
    mem_wdata      = CLEAR_CHAR;

    case (state)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        clr_ptr_nxt = clr_ptr + 6'd1;
        if (clr_ptr == 6'd63) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.clearReq) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end else if (rr_valid) begin
          grant_int      = 4'b0001 << rr_sel;
          mem_we         = 1'b1;
          mem_waddr      = req_addr[rr_sel];
          mem_wdata      = req_data[rr_sel];
          last_grant_nxt = rr_sel;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase

    // grant is combinational, so it must be forced quiet while reset is held
    // or a pending request would appear committed.
    if (!resetN) begin
      grant_int = '0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= ST_CLEAR;
      clr_ptr    <= '0;
      last_grant <= 2'd3;
      busy_q     <= 1'b1;
      char_q     <= CLEAR_CHAR;
    end else begin
      state      <= state_nxt;
      clr_ptr    <= clr_ptr_nxt;
      last_grant <= last_grant_nxt;
      busy_q     <= (state_nxt == ST_CLEAR);
      char_q     <= mem[bus.charAddress];
    end
  end

  // Storage has no reset; the sweep after reset release initialises it.
  // Same-edge read of mem returns old data through the non-blocking update.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.grant      = grant_int;
  assign bus.busy       = busy_q;
  assign bus.charOutput = char_q;

endmodule
